clock_ratio_monitor: RTL

Receive-side counterpart to the team's clock divider. Samples a divided-clock or strobe signal that is synchronous to `clk` and measures its rising-edge-to-rising-edge period and its high time, both in `clk` cycles. Declares lock after a run of identical periods. Reports mismatches and loss of signal. Sits next to divider outputs (e.g. /2, /3 taps) as an on-chip checker and ratio detector.

---
 rtl/clock_ratio_monitor_if.sv | 33 +++
 rtl/clock_ratio_monitor.sv | 109 ++++++++++
 2 files changed

// File: rtl/clock_ratio_monitor_if.sv
// Monitored strobe in, period / high-time measurements and status out.
// The monitor sits on the slave side; the source of sig_in is the master.
interface clock_ratio_monitor_if #(
    parameter int CNT_W = 8
);
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             locked;
    logic             err;
    logic             timeout;

    modport master (
        output sig_in,
        input  period,
        input  high_time,
        input  period_valid,
        input  locked,
        input  err,
        input  timeout
    );

    modport slave (
        input  sig_in,
        output period,
        output high_time,
        output period_valid,
        output locked,
        output err,
        output timeout
    );
endinterface

// File: rtl/clock_ratio_monitor.sv
// Measures period and high time of a clk-synchronous strobe, locks
// after LOCK_CNT equal periods, flags mismatches and loss of signal.
module clock_ratio_monitor #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input logic                  clk,
    input logic                  rst,
    clock_ratio_monitor_if.slave mon
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LOCK_M  = 4'(LOCK_CNT);

    state_t           state_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] ref_q;
    logic [3:0]       match_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_q;
    logic             pv_q;
    logic             locked_q;
    logic             err_q;
    logic             to_q;

    logic       rise;
    logic [3:0] match_inc;

    assign rise      = mon.sig_in & ~prev_q;
    assign match_inc = match_q + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prev_q   <= 1'b1;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            ref_q    <= '0;
            match_q  <= '0;
            period_q <= '0;
            high_q   <= '0;
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            prev_q <= mon.sig_in;
            pv_q   <= 1'b0;
            err_q  <= 1'b0;
            to_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // The arming edge already starts the first period.
                    cnt_q  <= rise ? CNT_ONE : '0;
                    hcnt_q <= rise ? CNT_ONE : '0;
                    if (rise) state_q <= ARM;
                end
                ARM, TRACK, LOCKED: begin
                    if (rise) begin
                        cnt_q    <= CNT_ONE;
                        hcnt_q   <= CNT_ONE;
                        period_q <= cnt_q;
                        high_q   <= hcnt_q;
                        pv_q     <= 1'b1;
                        if (state_q == ARM || cnt_q != ref_q) begin
                            ref_q    <= cnt_q;
                            match_q  <= 4'd1;
                            locked_q <= 1'b0;
                            state_q  <= TRACK;
                            if (state_q == LOCKED) err_q <= 1'b1;
                        end else if (state_q == TRACK) begin
                            match_q <= match_inc;
                            if (match_inc == LOCK_M) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        to_q     <= 1'b1;
                        locked_q <= 1'b0;
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        hcnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (mon.sig_in) hcnt_q <= hcnt_q + CNT_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mon.period       = period_q;
    assign mon.high_time    = high_q;
    assign mon.period_valid = pv_q;
    assign mon.locked       = locked_q;
    assign mon.err          = err_q;
    assign mon.timeout      = to_q;
endmodule
